// File: rtl/vga_timing_if.sv
// Bundle of VGA raster-timing signals passed from the timing generator to
// the frame renderer and the DAC pins.
//   master : timing generator (drives everything)
//   slave  : consumers (renderer, pin logic)
interface vga_timing_if;
  logic       VGA_CLK;      // pixel clock, Clk/2
  logic       pix_en;       // high on the Clk cycle whose closing edge advances the counters
  logic [9:0] DrawX;        // current horizontal count
  logic [9:0] DrawY;        // current vertical count
  logic       VGA_HS;       // horizontal sync, active low, delayed
  logic       VGA_VS;       // vertical sync, active low, delayed
  logic       VGA_BLANK_N;  // high inside the visible area, delayed
  logic       VGA_SYNC_N;   // tied 0
  logic       frame_clk;    // undelayed registered vertical sync
  logic       line_start;   // one-Clk pulse after hc wraps to 0
  logic       frame_start;  // one-Clk pulse after hc and vc both wrap to 0

  modport master (
    output VGA_CLK, pix_en, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N,
           VGA_SYNC_N, frame_clk, line_start, frame_start
  );

  modport slave (
    input  VGA_CLK, pix_en, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N,
           VGA_SYNC_N, frame_clk, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides the 50 MHz Clk by two into VGA_CLK, runs the pixel (hc) and line
// (vc) counters on the pixel-enable cycles, and derives the HS/VS/blank
// strobes. The strobes are registered once and then delayed by SYNC_DELAY
// more Clk stages so they reach the DAC alongside the renderer's colour.
// Ports:
//   Clk   : 50 MHz system clock
//   Reset : asynchronous, active-low reset
//   vga   : timing bundle (master side), see vga_timing_if
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  generate
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_sync_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
    end
  endgenerate

  // Toggle flop: doubles as VGA_CLK and pix_en. Counters advance on the
  // edge that ends a cycle where it is high, i.e. on VGA_CLK's falling edge.
  logic vclk_q, vclk_d;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;

  // Stage 0 is the single registration of the raw strobe; stages
  // 1..SYNC_DELAY are the colour-path alignment delay.
  logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DELAY:0] vs_pipe_q, vs_pipe_d;
  logic [SYNC_DELAY:0] bl_pipe_q, bl_pipe_d;

  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  logic hs_raw, vs_raw, blank_raw_n;

  always_comb begin
    vclk_d = ~vclk_q;

    hc_d = hc_q;
    vc_d = vc_q;
    if (vclk_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end

    hs_raw      = !((hc_q >= HS_START) && (hc_q < HS_END));
    vs_raw      = !((vc_q >= VS_START) && (vc_q < VS_END));
    blank_raw_n = (hc_q < H_VIS) && (vc_q < V_VIS);

    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    bl_pipe_d    = bl_pipe_q;
    hs_pipe_d[0] = hs_raw;
    vs_pipe_d[0] = vs_raw;
    bl_pipe_d[0] = blank_raw_n;
    for (int i = 1; i <= SYNC_DELAY; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
      bl_pipe_d[i] = bl_pipe_q[i-1];
    end

    // Set on the same edge that loads hc (and vc) with 0.
    line_start_d  = vclk_q && (hc_q == H_LAST);
    frame_start_d = line_start_d && (vc_q == V_LAST);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vclk_q        <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      bl_pipe_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vclk_q        <= vclk_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      bl_pipe_q     <= bl_pipe_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.VGA_CLK     = vclk_q;
  assign vga.pix_en      = vclk_q;
  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.VGA_HS      = hs_pipe_q[SYNC_DELAY];
  assign vga.VGA_VS      = vs_pipe_q[SYNC_DELAY];
  assign vga.VGA_BLANK_N = bl_pipe_q[SYNC_DELAY];
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.frame_clk   = vs_pipe_q[0];
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (15 x 8) so whole frames
// fit in a short run. Two instances share Clk/Reset: SYNC_DELAY=0 and 3.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;  // 15
  localparam int VT = VV + VF + VS + VB;  // 8
  localparam int NF = HT * VT * 2;        // Clk per frame: 240

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  vga_timing_if if0 ();
  vga_timing_if if3 ();

  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .SYNC_DELAY(0)) u0 (.Clk(Clk), .Reset(Reset), .vga(if0));
  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .SYNC_DELAY(3)) u3 (.Clk(Clk), .Reset(Reset), .vga(if3));

  typedef struct packed {
    logic [9:0] x, y;
    logic vclk, pix, hs, vs, bl, sync_n, fclk, ls, fs;
  } obs_t;

  localparam obs_t RST = '{x: 10'd0, y: 10'd0, vclk: 1'b0, pix: 1'b0, hs: 1'b1,
                           vs: 1'b1, bl: 1'b0, sync_n: 1'b0, fclk: 1'b1,
                           ls: 1'b0, fs: 1'b0};

  int checks = 0;
  int errors = 0;
  int e = 0;  // Clk edges since reset release
  obs_t q0[$], q3[$];
  obs_t hist0 [0:1023];
  obs_t hist3 [0:1023];

  // Closed-form reference: state after edge e, derived from the pixel index
  // floor(e/2); delayed strobes look at the state (1+sd) edges earlier.
  function automatic obs_t model(int ev, int sd);
    obs_t o;
    int p, k, q, hq, vq, f;
    p = ev / 2;
    o.x = 10'(p % HT);
    o.y = 10'((p / HT) % VT);
    o.vclk = ev[0];
    o.pix = ev[0];
    o.sync_n = 1'b0;
    k = ev - 1 - sd;
    if (k < 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.bl = 1'b0;
    end else begin
      q = k / 2; hq = q % HT; vq = (q / HT) % VT;
      o.hs = !(hq >= HV + HF && hq < HV + HF + HS);
      o.vs = !(vq >= VV + VF && vq < VV + VF + VS);
      o.bl = (hq < HV) && (vq < VV);
    end
    f = ((ev - 1) / 2 / HT) % VT;
    o.fclk = !(f >= VV + VF && f < VV + VF + VS);
    o.ls = (ev % 2 == 0) && (p % HT == 0);
    o.fs = o.ls && ((p / HT) % VT == 0);
    return o;
  endfunction

  function automatic obs_t obs0();
    obs_t o;
    o = '{x: if0.DrawX, y: if0.DrawY, vclk: if0.VGA_CLK, pix: if0.pix_en,
          hs: if0.VGA_HS, vs: if0.VGA_VS, bl: if0.VGA_BLANK_N,
          sync_n: if0.VGA_SYNC_N, fclk: if0.frame_clk, ls: if0.line_start,
          fs: if0.frame_start};
    return o;
  endfunction

  function automatic obs_t obs3();
    obs_t o;
    o = '{x: if3.DrawX, y: if3.DrawY, vclk: if3.VGA_CLK, pix: if3.pix_en,
          hs: if3.VGA_HS, vs: if3.VGA_VS, bl: if3.VGA_BLANK_N,
          sync_n: if3.VGA_SYNC_N, fclk: if3.frame_clk, ls: if3.line_start,
          fs: if3.frame_start};
    return o;
  endfunction

  task automatic chk(input string n, input int ev, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s e=%0d got=%0h exp=%0h", n, ev, got, exp);
    end
  endtask

  task automatic chk_rst(input string n);
    chk({n, "_sd0"}, e, 32'(obs0()), 32'(RST));
    chk({n, "_sd3"}, e, 32'(obs3()), 32'(RST));
  endtask

  // One Clk: expected values queued at the edge, popped and compared when
  // the outputs are sampled on the falling edge.
  task automatic step();
    obs_t g0, g3, x0, x3;
    @(posedge Clk);
    e++;
    q0.push_back(model(e, 0));
    q3.push_back(model(e, 3));
    @(negedge Clk);
    g0 = obs0();
    g3 = obs3();
    x0 = q0.pop_front();
    x3 = q3.pop_front();
    chk("sb_sd0", e, 32'(g0), 32'(x0));
    chk("sb_sd3", e, 32'(g3), 32'(x3));
    if (e < 1024) begin
      hist0[e] = g0;
      hist3[e] = g3;
    end
  endtask

  // Hand-derived spot vectors for the 15x8 raster.
  typedef struct {
    int ev;
    logic [9:0] x, y;
    logic hs0, hs3, vs0, vs3, bl0, bl3, ls, fs;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int n_hs0, n_hs3, n_vs0, n_vs3, n_bl0, n_bl3, n_ls, n_fs, n_fr, n_vh, n_sn;
    int r0, r3, eh, f0, f3, fs_at;
    bit found;

    tbl[0]  = '{1,   10'd0,  10'd0, 1,1, 1,1, 1,0, 0,0};
    tbl[1]  = '{3,   10'd1,  10'd0, 1,1, 1,1, 1,0, 0,0};
    tbl[2]  = '{4,   10'd2,  10'd0, 1,1, 1,1, 1,1, 0,0};
    tbl[3]  = '{16,  10'd8,  10'd0, 1,1, 1,1, 1,1, 0,0};
    tbl[4]  = '{17,  10'd8,  10'd0, 1,1, 1,1, 0,1, 0,0};
    tbl[5]  = '{20,  10'd10, 10'd0, 1,1, 1,1, 0,0, 0,0};
    tbl[6]  = '{21,  10'd10, 10'd0, 0,1, 1,1, 0,0, 0,0};
    tbl[7]  = '{24,  10'd12, 10'd0, 0,0, 1,1, 0,0, 0,0};
    tbl[8]  = '{27,  10'd13, 10'd0, 1,0, 1,1, 0,0, 0,0};
    tbl[9]  = '{30,  10'd0,  10'd1, 1,1, 1,1, 0,0, 1,0};
    tbl[10] = '{31,  10'd0,  10'd1, 1,1, 1,1, 1,0, 0,0};
    tbl[11] = '{151, 10'd0,  10'd5, 1,1, 0,1, 0,0, 0,0};
    tbl[12] = '{154, 10'd2,  10'd5, 1,1, 0,0, 0,0, 0,0};
    tbl[13] = '{211, 10'd0,  10'd7, 1,1, 1,0, 0,0, 0,0};
    tbl[14] = '{214, 10'd2,  10'd7, 1,1, 1,1, 0,0, 0,0};
    tbl[15] = '{239, 10'd14, 10'd7, 1,0, 1,1, 0,0, 0,0};
    tbl[16] = '{240, 10'd0,  10'd0, 1,1, 1,1, 0,0, 1,1};
    tbl[17] = '{241, 10'd0,  10'd0, 1,1, 1,1, 1,0, 0,0};
    tbl[18] = '{244, 10'd2,  10'd0, 1,1, 1,1, 1,1, 0,0};

    // Reset held for 3 Clk.
    repeat (3) begin
      @(negedge Clk);
      chk_rst("rst_hold");
    end

    // Release between edges; next rising edge is edge 1.
    Reset = 1'b1;
    e = 0;
    repeat (2 * NF) step();

    foreach (tbl[i]) begin
      chk($sformatf("vec%0d", i), tbl[i].ev,
          32'({hist0[tbl[i].ev].x, hist0[tbl[i].ev].y,
               hist0[tbl[i].ev].hs, hist3[tbl[i].ev].hs,
               hist0[tbl[i].ev].vs, hist3[tbl[i].ev].vs,
               hist0[tbl[i].ev].bl, hist3[tbl[i].ev].bl,
               hist0[tbl[i].ev].ls, hist0[tbl[i].ev].fs}),
          32'({tbl[i].x, tbl[i].y, tbl[i].hs0, tbl[i].hs3, tbl[i].vs0,
               tbl[i].vs3, tbl[i].bl0, tbl[i].bl3, tbl[i].ls, tbl[i].fs}));
    end

    // Whole-frame statistics over the second frame (edges 241..480).
    n_hs0 = 0; n_hs3 = 0; n_vs0 = 0; n_vs3 = 0; n_bl0 = 0; n_bl3 = 0;
    n_ls = 0; n_fs = 0; n_fr = 0; n_vh = 0; n_sn = 0;
    r0 = 0; r3 = 0; eh = 0; f0 = 0; f3 = 0;
    for (int i = NF + 1; i <= 2 * NF; i++) begin
      n_hs0 += int'(!hist0[i].hs);
      n_hs3 += int'(!hist3[i].hs);
      n_vs0 += int'(!hist0[i].vs);
      n_vs3 += int'(!hist3[i].vs);
      n_bl0 += int'(hist0[i].bl);
      n_bl3 += int'(hist3[i].bl);
      n_ls  += int'(hist0[i].ls);
      n_fs  += int'(hist0[i].fs);
      n_fr  += int'(hist0[i].fclk && !hist0[i-1].fclk);
      n_vh  += int'(hist0[i].vclk);
      n_sn  += int'(hist0[i].sync_n) + int'(hist3[i].sync_n);
      if (r0 == 0 && hist0[i].bl && !hist0[i-1].bl) r0 = i;
      if (r3 == 0 && hist3[i].bl && !hist3[i-1].bl) r3 = i;
      if (eh == 0 && hist0[i].x == 10'(HV + HF) && hist0[i-1].x != 10'(HV + HF)) eh = i;
      if (eh != 0 && f0 == 0 && !hist0[i].hs && hist0[i-1].hs) f0 = i;
      if (eh != 0 && f3 == 0 && !hist3[i].hs && hist3[i-1].hs) f3 = i;
    end
    chk("hs_low_sd0",   0, n_hs0, VT * HS * 2);
    chk("hs_low_sd3",   0, n_hs3, VT * HS * 2);
    chk("vs_low_sd0",   0, n_vs0, HT * VS * 2);
    chk("vs_low_sd3",   0, n_vs3, HT * VS * 2);
    chk("blank_hi_sd0", 0, n_bl0, VV * HV * 2);
    chk("blank_hi_sd3", 0, n_bl3, VV * HV * 2);
    chk("line_starts",  0, n_ls, VT);
    chk("frame_starts", 0, n_fs, 1);
    chk("fclk_rises",   0, n_fr, 1);
    chk("vclk_high",    0, n_vh, NF / 2);
    chk("sync_n_high",  0, n_sn, 0);
    chk("blank_shift",  0, r3 - r0, 3);
    chk("hs_lat_sd0",   0, f0 - eh, 1);
    chk("hs_lat_sd3",   0, f3 - eh, 4);

    // Mid-frame reset at (7,2): effect must be immediate.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (if0.DrawX == 10'd7 && if0.DrawY == 10'd2) found = 1;
    end
    chk("reach_7_2", e, 32'(found), 32'd1);
    #2 Reset = 1'b0;
    #1 chk_rst("rst_async");
    @(posedge Clk);
    @(negedge Clk);
    chk_rst("rst_edge");

    // Restart from (0,0): next frame_start exactly one frame after release.
    Reset = 1'b1;
    e = 0;
    fs_at = 0;
    for (int i = 0; i < NF + 20 && fs_at == 0; i++) begin
      step();
      if (if0.frame_start) fs_at = e;
    end
    chk("restart_fs", fs_at, fs_at, NF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Produces VGA raster timing for the pixel-colour path: pixel/line counters, DrawX/DrawY coordinates, HS/VS/blanking strobes, the 25 MHz VGA_CLK and the ~60 Hz frame_clk. It drives the DrawX/DrawY inputs of the frame renderer. Its delayed sync outputs line up with the renderer's registered VGA_R/G/B at the DAC.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_DELAY, 1, extra Clk stages applied to VGA_HS/VGA_VS/VGA_BLANK_N to match colour-path latency (0..4)

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  asynchronous, active-low reset
VGA_CLK  out  1  pixel clock, Clk/2
pix_en  out  1  one-Clk strobe, high on the Clk cycle where the counters advance
DrawX  out  10  current horizontal count, 0..H_TOTAL-1
DrawY  out  10  current vertical count, 0..V_TOTAL-1
VGA_HS  out  1  horizontal sync, active low, delayed
VGA_VS  out  1  vertical sync, active low, delayed
VGA_BLANK_N  out  1  high while inside the visible area, delayed
VGA_SYNC_N  out  1  tied 0
frame_clk  out  1  undelayed copy of vertical sync; its rising edge marks the end of sync
line_start  out  1  one-Clk pulse when hc wraps to 0 (qualified by pix_en)
frame_start  out  1  one-Clk pulse when hc and vc both wrap to 0

Behaviour:
- Derived widths: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Counters are 10-bit unsigned.
- Reset asserted (low), asynchronous:
  - hc=0, vc=0, VGA_CLK=0, pix_en=0.
  - All HS/VS delay stages=1; all BLANK_N stages=0.
  - line_start=0, frame_start=0.
  - The effect is immediate and does not wait for a Clk edge.
- Reset release: first rising Clk edge sets the VGA_CLK toggle flop to 1. pix_en = registered toggle, asserted every second Clk starting with the 2nd edge after release.
- Horizontal counter, when pix_en=1: hc <= (hc==H_TOTAL-1) ? 0 : hc+1.
- Vertical counter: vc changes only when pix_en=1 and hc==H_TOTAL-1. vc <= (vc==V_TOTAL-1) ? 0 : vc+1.
- When pix_en=0, counters hold.
- DrawX=hc and DrawY=vc, driven directly from the counter registers (zero latency).
- Raw strobes, combinational from the counters:
  - hs_raw=0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs_raw=0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
  - blank_raw_n=1 iff hc<H_VISIBLE and vc<V_VISIBLE.
- Raw strobes are registered once, then passed through SYNC_DELAY further Clk stages. Total latency from counter change to pin = 1+SYNC_DELAY Clk.
- frame_clk = the 1-stage registered vs_raw (no extra delay). Its rising edge occurs 1 Clk after vc changes from 491 to 492.
- line_start: registered; =1 for the single Clk after the edge where hc loaded 0.
- frame_start: same rule, but also requires vc loaded 0.
- Reset mid-frame: counters return to 0 asynchronously. After release, timing restarts from (0,0). No partial-line recovery.
- Parameter sanity: SYNC_DELAY outside 0..4 must produce an elaboration error.

Test Plan:
- Reset low for 3 Clk, then release:
  - during reset: DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_CLK=0;
  - after release: first pix_en on the 2nd Clk edge; DrawX=1 after that edge.
- Run one line: hc steps 0..799 then wraps to 0, vc goes 0→1 on the same edge, line_start pulses once. VGA_HS low for exactly 192 Clk, with its first low cycle 1+SYNC_DELAY Clk after hc reaches 656.
- Run a full frame (800*525*2 = 840000 Clk): VGA_VS low for exactly 3200 Clk. Exactly one frame_clk rising edge. frame_start pulses once, at vc=0,hc=0.
- Blanking: VGA_BLANK_N=1 for 640*2 Clk per line on lines 0..479, and 0 for all of lines 480..524. Checked at SYNC_DELAY=0 and at SYNC_DELAY=3; the edge positions shift by exactly 3 Clk.
- Assert Reset at hc=300, vc=200: all outputs return to reset values with no Clk edge. After release, the next frame_start occurs 840000 Clk after the restart.
- VGA_SYNC_N=0 at all times; VGA_CLK period = 2 Clk with 50% duty throughout.
